// File: rtl/call_return_ctrl_pkg.sv
// Shared encodings for the call/return PC sequencer.
// Optional depth tracking is enabled with CALLRET_DEPTH_CHECK_EN.
package cr_pkg;

    localparam logic IDLE     = 1'b0;
    localparam logic CMD      = 1'b1;

    localparam logic STK_PUSH = 1'b0;
    localparam logic STK_POP  = 1'b1;

    typedef enum logic {
        ST_IDLE = IDLE,
        ST_CMD  = CMD
    } state_t;

endpackage

// File: rtl/call_return_ctrl_if.sv
// Bus between the sequencer (master) and the return-address stack (slave).
// stk_nclr is the stack's active-low clear.
interface call_return_ctrl_if #(parameter int width = 8);

    logic [width-1:0] stk_peek;
    logic [width-1:0] stk_push;
    logic             stk_c;
    logic             stk_en;
    logic             stk_nclr;

    modport master (input stk_peek, output stk_push, output stk_c, output stk_en, output stk_nclr);
    modport slave  (output stk_peek, input stk_push, input stk_c, input stk_en, input stk_nclr);

endinterface

// File: rtl/call_return_ctrl_depth_cnt.sv
// Up/down occupancy counter mirroring the attached stack; flags full/empty.
// Only instantiated when CALLRET_DEPTH_CHECK_EN is defined.
module cr_depth_cnt #(
    parameter int depth = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam logic [depth:0] CAP = {1'b1, {depth{1'b0}}};

    logic [depth:0] count;

    // count saturates at 0 and at capacity; callers only pulse inc/dec when legal
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc && !full)
            count <= count + 1'b1;
        else if (dec && !empty)
            count <= count - 1'b1;
    end

    assign full  = (count == CAP);
    assign empty = (count == '0);

endmodule

// File: rtl/call_return_ctrl.sv
// PC sequencer issuing push/pop commands to a return-address stack.
// CALLRET_DEPTH_CHECK_EN: track stack depth, refuse CALL at full / RET at
// empty and raise sticky overflow/underflow. Undefined: always accept.
module call_return_ctrl
    import cr_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             step,
    input  logic             call,
    input  logic             ret,
    input  logic [width-1:0] target,
    output logic [width-1:0] pc,
    output logic             busy,
    output logic             overflow,
    output logic             underflow,
    call_return_ctrl_if.master bus
);

    state_t           state, state_nxt;
    logic [width-1:0] pc_nxt;
    logic [width-1:0] push_q, push_nxt;
    logic             cmd_q, cmd_nxt;
    logic             en_q;
    logic             issue;
    logic             full, empty;

`ifdef CALLRET_DEPTH_CHECK_EN
    logic ovf_q, unf_q;

    cr_depth_cnt #(.depth(depth)) u_depth_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (issue && (cmd_nxt == STK_PUSH)),
        .dec   (issue && (cmd_nxt == STK_POP)),
        .full  (full),
        .empty (empty)
    );

    // refusals are only possible from IDLE; call wins over ret
    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (call && full)
                ovf_q <= 1'b1;
            if (!call && ret && empty)
                unf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign full      = 1'b0;
    assign empty     = 1'b0;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    // state and registered outputs; a command lasts exactly one CMD cycle
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_IDLE;
            pc     <= '0;
            push_q <= '0;
            cmd_q  <= STK_PUSH;
            en_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            push_q <= push_nxt;
            cmd_q  <= cmd_nxt;
            en_q   <= issue;
        end
    end

    // request decode in IDLE with priority call > ret > step; CMD ignores all
    always_comb begin
        pc_nxt   = pc;
        push_nxt = push_q;
        cmd_nxt  = cmd_q;
        issue    = 1'b0;
        if (state == ST_IDLE) begin
            if (call) begin
                if (!full) begin
                    issue    = 1'b1;
                    cmd_nxt  = STK_PUSH;
                    pc_nxt   = target;
                    push_nxt = pc + width'(1);
                end
            end else if (ret) begin
                if (!empty) begin
                    issue   = 1'b1;
                    cmd_nxt = STK_POP;
                    pc_nxt  = bus.stk_peek;
                end
            end else if (step) begin
                pc_nxt = pc + width'(1);
            end
        end
        state_nxt = issue ? ST_CMD : ST_IDLE;
    end

    assign busy         = (state == ST_CMD);
    assign bus.stk_push = push_q;
    assign bus.stk_c    = cmd_q;
    assign bus.stk_en   = en_q;
    assign bus.stk_nclr = ~clr;

endmodule

// File: doc/call_return_ctrl.md
# call_return_ctrl

Program-counter sequencer that drives the processor's parameterized return-address stack from the initiator side. It advances the PC, issues push commands on CALL (saving PC+1) and pop commands on RET (restoring the saved address), and keeps a local depth count to flag overflow and underflow. It sits between the instruction decoder and the stack instance in the datapath.

## Interface
- width, 8: PC and return-address width in bits
- depth, 1: log2 of stack entries; must match the attached stack instance (capacity 2**depth)

- clk  in  1  system clock, rising edge
- clr  in  1  reset, synchronous, active-high
- step  in  1  advance PC by one
- call  in  1  jump to target, push PC+1
- ret  in  1  pop and jump to saved address
- target  in  width  call destination
- stk_peek  in  width  stack top-of-stack value
- pc  out  width  current program counter (registered)
- stk_push  out  width  value presented to stack push input (registered)
- stk_c  out  1  stack command: 0 push, 1 pop (registered)
- stk_en  out  1  stack command enable (registered)
- busy  out  1  command in flight; step/call/ret ignored
- overflow  out  1  sticky, CALL refused at full
- underflow  out  1  sticky, RET refused at empty

## Operation
- States: IDLE, CMD. Reset → IDLE.
- IDLE request priority: call > ret > step. Lower-priority requests in the same cycle are dropped.
- CALL in IDLE with count < 2**depth:
  - pc ← target; stk_push ← pc+1; stk_c ← 0; stk_en ← 1; count+1; → CMD.
- CALL at count == 2**depth:
  - overflow ← 1; pc unchanged; no stack command; stay IDLE.
- RET in IDLE with count > 0:
  - pc ← stk_peek; stk_c ← 1; stk_en ← 1; count−1; → CMD.
- RET at count == 0:
  - underflow ← 1; pc unchanged; no command; stay IDLE.
- STEP in IDLE: pc ← pc+1.
- CMD: stk_en ← 0; → IDLE unconditionally. All requests are ignored in CMD and are not queued.
- busy = (state == CMD).
- Arithmetic: pc+1 is modulo 2**width; 0xFF+1 → 0x00 at width 8. count is depth+1 bits and ranges 0..2**depth.
- overflow and underflow clear only on clr.
- The stack's clear is active-low; the top level drives it with ~clr.

## Timing
- Reset values:
  - pc=0, stk_push=0, stk_c=0, stk_en=0, busy=0, overflow=0, underflow=0
  - count=0, state IDLE
- Command latency:
  - The request is sampled at edge E1; stk_en is high during E1→E2; the stack samples at E2.
  - stk_peek reflects the new top from E2 onward, i.e. during the following IDLE cycle.
- busy is high for exactly one cycle per accepted CALL/RET. Back-to-back requests can be accepted every other cycle.
- pc updates at E1 for CALL, RET and STEP alike.
- clr mid-CMD: at the next edge all outputs take their reset values; stk_en drops and the in-flight command is abandoned.

## Configuration
- CALLRET_DEPTH_CHECK_EN
  - Defined: count, refusal at full/empty and sticky flags operate as above.
  - Undefined: no counter. CALL and RET are always accepted and always issue stack commands. overflow and underflow are tied to 0. Over-push and over-pop are absorbed by the stack itself, but pc still jumps.

## Structure
- Package cr_pkg holds:
  - state encoding localparams IDLE=1'b0 and CMD=1'b1
  - command constants STK_PUSH=1'b0 and STK_POP=1'b1
- One sub-module, cr_depth_cnt: an up/down saturating-detect counter with inc, dec, full and empty outputs. It is compiled only under CALLRET_DEPTH_CHECK_EN.

## Test plan
All scenarios use width=8, depth=1 (2 entries) and CALLRET_DEPTH_CHECK_EN defined unless noted. The attached stack is a real instance.
- Reset, then step ×3 → pc=0x03; stk_en never asserted.
- At pc=0x03, call with target=0x40 → next edge: pc=0x40, stk_en=1, stk_c=0, stk_push=0x04, busy=1 for one cycle. Following cycle: stk_peek=0x04.
- Two calls (0x40, then 0x80), then a third call to 0xC0 → overflow=1, pc stays 0x80, no stk_en. Then ret → pc=0x41, ret → pc=0x04.
- Ret at count 0 → underflow=1, pc unchanged. Assert call+ret together in IDLE → call taken. Assert call during busy → ignored, pc unchanged.
- Assert clr during CMD → next edge: all outputs 0, state IDLE. With the macro undefined, a third call → pc jumps, overflow stays 0.
